// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the pipelined ALU and its sequential multiplier.
package alu_pkg;

  typedef enum logic [1:0] {
    OT_MOVE  = 2'b00,
    OT_ARITH = 2'b01,
    OT_LOGIC = 2'b10,
    OT_RSVD  = 2'b11
  } op_type_e;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_DEC = 4'd3;
  localparam logic [3:0] OP_MUL = 4'd4;
  localparam logic [3:0] OP_NEG = 4'd5;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_NOT = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one iteration per clock after start; done flags the edge on which
// the final iteration lands, with result presenting the product that edge will produce.
module alu_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign result   = acc_next;
  assign busy     = (cnt != '0);
  assign done     = (cnt == CNT_W'(1));

  // Only the low WIDTH product bits are kept, so the multiplicand may shift out freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= CNT_W'(WIDTH);
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and a sequential multiplier.
// Optional build macro ALU_SIGNED_CMP_EN: signed gt/lt and arithmetic right shift (logic opcode 7).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  op1,
  input  logic [WIDTH-1:0]  op2,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [1:0]        op_type,
  input  logic [3:0]        opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  alu_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              za,
  output logic              zb,
  output logic              eq,
  output logic              gt,
  output logic              lt,
  output logic              busy
);

  localparam int SH_W = $clog2(WIDTH);

  state_t            state;
  logic              rdy_q;
  logic              accept;
  logic              is_mul;
  logic              load_flags;
  logic [WIDTH-1:0]  res;
  logic [ADDR_W-1:0] res_addr;
  logic [ADDR_W-1:0] mul_addr;
  logic [WIDTH-1:0]  mul_result;
  logic              mul_done;
  logic [SH_W-1:0]   sh;
  logic              gt_c;
  logic              lt_c;

  assign sh       = op2[SH_W-1:0];
  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready = rdy_q && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_SIGNED_CMP_EN
  assign gt_c = $signed(op1) > $signed(op2);
  assign lt_c = $signed(op1) < $signed(op2);
`else
  assign gt_c = op1 > op2;
  assign lt_c = op1 < op2;
`endif

  always_comb begin
    res        = '0;
    res_addr   = dst_addr;
    is_mul     = 1'b0;
    load_flags = 1'b0;
    case (op_type_e'(op_type))
      OT_MOVE: res = op2;
      OT_ARITH: begin
        case (opcode)
          OP_ADD:  res = op1 + op2;
          OP_SUB:  res = op1 - op2;
          OP_INC:  res = op1 + WIDTH'(1);
          OP_DEC:  res = op1 - WIDTH'(1);
          OP_MUL:  is_mul = 1'b1;
          OP_NEG:  res = '0 - op1;
          default: res = '0;
        endcase
      end
      OT_LOGIC: begin
        load_flags = 1'b1;
        case (opcode)
          OP_AND:  res = op1 & op2;
          OP_OR:   res = op1 | op2;
          OP_XOR:  res = op1 ^ op2;
          OP_NOT:  res = ~op1;
          OP_SHL:  res = op1 << sh;
          OP_SHR:  res = op1 >> sh;
          OP_CMP:  res = '0;
`ifdef ALU_SIGNED_CMP_EN
          OP_SRA:  res = $unsigned($signed(op1) >>> sh);
`endif
          default: res = '0;
        endcase
      end
      OT_RSVD:  res_addr = '0;
      default:  res_addr = '0;
    endcase
  end

  alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_mul),
    .a      (op1),
    .b      (op2),
    .result (mul_result),
    .busy   (busy),
    .done   (mul_done)
  );

  // A new load on the same edge as a consume overwrites the result, so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rdy_q     <= 1'b0;
      out_valid <= 1'b0;
      alu_out   <= '0;
      addr_out  <= '0;
      mul_addr  <= '0;
      za        <= 1'b0;
      zb        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (state == ST_MUL) begin
        if (mul_done) begin
          alu_out   <= mul_result;
          addr_out  <= mul_addr;
          out_valid <= 1'b1;
          state     <= ST_IDLE;
        end
      end else if (accept) begin
        if (is_mul) begin
          state    <= ST_MUL;
          mul_addr <= dst_addr;
        end else begin
          alu_out   <= res;
          addr_out  <= res_addr;
          out_valid <= 1'b1;
          if (load_flags) begin
            za <= (op1 == '0);
            zb <= (op2 == '0);
            eq <= (op1 == op2);
            gt <= gt_c;
            lt <= lt_c;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_alu_pipe;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [1:0]    op_type = '0;
  logic [3:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  alu_out;
  logic [AW-1:0] addr_out;
  logic          za, zb, eq, gt, lt, busy;

  typedef struct {
    logic [W-1:0]  res;
    logic [AW-1:0] addr;
    int            due;
  } exp_t;

  exp_t       q[$];
  logic [4:0] mflags = '0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         took = 1'b0;

`ifdef ALU_SIGNED_CMP_EN
  localparam logic [4:0] CMP_FLAGS = 5'b00001;
`else
  localparam logic [4:0] CMP_FLAGS = 5'b00010;
`endif

  alu_pipe #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .dst_addr(dst_addr), .op_type(op_type), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out), .addr_out(addr_out),
    .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected result of one accepted operation; c is the cycle count at acceptance.
  function automatic exp_t model_result(logic [1:0] t, logic [3:0] o, logic [W-1:0] a,
                                        logic [W-1:0] b, logic [AW-1:0] d, int c);
    exp_t        m;
    logic [31:0] p;
    int          s;
    s      = int'(b[3:0]);
    m.res  = '0;
    m.addr = d;
    m.due  = c + 1;
    case (t)
      2'd0: m.res = b;
      2'd1: begin
        case (o)
          4'd0: m.res = W'(a + b);
          4'd1: m.res = W'(a - b);
          4'd2: m.res = W'(a + 16'd1);
          4'd3: m.res = W'(a - 16'd1);
          4'd4: begin
            p     = {16'h0, a} * {16'h0, b};
            m.res = p[15:0];
            m.due = c + 1 + W;
          end
          4'd5: m.res = W'(16'd0 - a);
          default: m.res = '0;
        endcase
      end
      2'd2: begin
        case (o)
          4'd0: m.res = a & b;
          4'd1: m.res = a | b;
          4'd2: m.res = a ^ b;
          4'd3: m.res = ~a;
          4'd4: m.res = a << s;
          4'd5: m.res = a >> s;
`ifdef ALU_SIGNED_CMP_EN
          4'd7: m.res = $unsigned($signed(a) >>> s);
`endif
          default: m.res = '0;
        endcase
      end
      default: m.addr = '0;
    endcase
    return m;
  endfunction

  function automatic logic [4:0] model_flags(logic [W-1:0] a, logic [W-1:0] b);
`ifdef ALU_SIGNED_CMP_EN
    return {a == 0, b == 0, a == b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
`else
    return {a == 0, b == 0, a == b, a > b, a < b};
`endif
  endfunction

  // Per-cycle comparison against the model; model state advances after the checks.
  always @(negedge clk) begin
    bit exp_ov;
    bit mul_pend;
    bit exp_ir;
    if (!rst_n) begin
      check_output("reset_outputs",
                   32'({out_valid, alu_out, addr_out, za, zb, eq, gt, lt, busy, in_ready}), 32'd0);
      q.delete();
      mflags = '0;
      took   = 1'b0;
    end else begin
      exp_ov   = (q.size() > 0) && (q[0].due <= cyc);
      mul_pend = (q.size() > 0) && (q[0].due > cyc);
      exp_ir   = (cyc >= 1) && !mul_pend && (!exp_ov || out_ready);
      check_output("in_ready", 32'(in_ready), 32'(exp_ir));
      check_output("busy", 32'(busy), 32'(mul_pend));
      check_output("out_valid", 32'(out_valid), 32'(exp_ov));
      check_output("flags", 32'({za, zb, eq, gt, lt}), 32'(mflags));
      if (exp_ov) begin
        check_output("alu_out", 32'(alu_out), 32'(q[0].res));
        check_output("addr_out", 32'(addr_out), 32'(q[0].addr));
        if (out_ready) void'(q.pop_front());
      end
      took = in_valid && exp_ir;
      if (took) begin
        q.push_back(model_result(op_type, opcode, op1, op2, dst_addr, cyc));
        if (op_type == 2'd2) mflags = model_flags(op1, op2);
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] t, input logic [3:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [AW-1:0] d);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; op_type = t; opcode = o; op1 = a; op2 = b; dst_addr = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check_output("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [W-1:0] r, output logic [AW-1:0] ad, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
    if (!out_valid) check_output("result_timeout", 32'd0, 32'd1);
    r  = alu_out;
    ad = addr_out;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 3));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [W-1:0]  r;
    logic [AW-1:0] ad;
    int            n;
    int            seen;

    #12;
    check_output("reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;

    apply_stimulus(2'd1, 4'd0, 16'h0003, 16'h0004, 3'd5);
    wait_result(r, ad, n);
    check_output("add_result", 32'(r), 32'h0007);
    check_output("add_addr", 32'(ad), 32'd5);
    check_output("add_latency", 32'(n), 32'd1);
    check_output("add_flags_held", 32'({za, zb, eq, gt, lt}), 32'd0);

    apply_stimulus(2'd1, 4'd1, 16'h0000, 16'h0001, 3'd1);
    wait_result(r, ad, n);
    check_output("sub_wrap", 32'(r), 32'hFFFF);
    apply_stimulus(2'd1, 4'd3, 16'h0000, 16'h1234, 3'd1);
    wait_result(r, ad, n);
    check_output("dec_wrap", 32'(r), 32'hFFFF);

    apply_stimulus(2'd2, 4'd6, 16'hFFFF, 16'h0001, 3'd3);
    wait_result(r, ad, n);
    check_output("cmp_result", 32'(r), 32'd0);
    check_output("cmp_flags", 32'({za, zb, eq, gt, lt}), 32'(CMP_FLAGS));
    apply_stimulus(2'd1, 4'd0, 16'h0000, 16'h0000, 3'd0);
    wait_result(r, ad, n);
    check_output("flags_held_after_add", 32'({za, zb, eq, gt, lt}), 32'(CMP_FLAGS));

    apply_stimulus(2'd1, 4'd4, 16'h0012, 16'h0034, 3'd2);
    wait_result(r, ad, n);
    check_output("mul_result", 32'(r), 32'h03A8);
    check_output("mul_addr", 32'(ad), 32'd2);
    check_output("mul_latency", 32'(n), 32'd17);
    apply_stimulus(2'd1, 4'd4, 16'hFFFF, 16'hFFFF, 3'd6);
    wait_result(r, ad, n);
    check_output("mul_ffff", 32'(r), 32'h0001);

    apply_stimulus(2'd3, 4'd9, 16'hABCD, 16'h1234, 3'd7);
    wait_result(r, ad, n);
    check_output("rsvd_result", 32'(r), 32'd0);
    check_output("rsvd_addr", 32'(ad), 32'd0);

    // Backpressure, then a consume and accept on the same edge.
    apply_stimulus(2'd2, 4'd0, 16'h1234, 16'h0FF0, 3'd4);
    out_ready = 1'b0;
    in_valid = 1'b1; op_type = 2'd2; opcode = 4'd2; op1 = 16'h00FF; op2 = 16'h0F0F; dst_addr = 3'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("bp_valid", 32'(out_valid), 32'd1);
      check_output("bp_data", 32'(alu_out), 32'h0230);
      check_output("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("swap_valid", 32'(out_valid), 32'd1);
    check_output("swap_data", 32'(alu_out), 32'h0FF0);
    check_output("swap_addr", 32'(addr_out), 32'd6);

    // Reset in the middle of a multiply.
    apply_stimulus(2'd1, 4'd4, 16'h0005, 16'h0007, 3'd3);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_busy", 32'(busy), 32'd0);
    check_output("async_reset_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_output("no_stale_product", 32'(seen), 32'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          op_type  = 2'($urandom_range(0, 3));
          opcode   = 4'($urandom_range(0, 9));
          if ($urandom_range(0, 11) == 0) begin
            op_type = 2'd1;
            opcode  = 4'd4;
          end
          op1      = pick_operand();
          op2      = ($urandom_range(0, 7) == 0) ? op1 : pick_operand();
          dst_addr = AW'($urandom);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    check_output("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Accepts one operation per valid/ready handshake and produces registered result, destination register address and compare flags.
- Adds a multi-cycle sequential multiplier with output backpressure.
- Sits between register-file read and write-back in the CPU datapath.

Parameters:
- WIDTH, 16: data width of op1, op2 and alu_out; must be >= 4.
- ADDR_W, 3: register-address width for dst_addr and addr_out.
- CNT_W, $clog2(WIDTH+1): multiplier iteration-counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation present on inputs.
- in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready.
- op1  in  WIDTH  first operand.
- op2  in  WIDTH  second operand / move data.
- dst_addr  in  ADDR_W  destination register address.
- op_type  in  2  00 move, 01 arith, 10 logic, 11 reserved.
- opcode  in  4  operation within class.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  consumer accepts; transfer occurs when out_valid && out_ready.
- alu_out  out  WIDTH  result.
- addr_out  out  ADDR_W  write-back address.
- za, zb, eq, gt, lt  out  1 each  compare flags: op1==0, op2==0, op1==op2, op1>op2, op1<op2.
- busy  out  1  high while the multiplier is iterating.

Behaviour:
- Reset: all outputs 0, state IDLE, multiplier registers cleared; in_ready goes high on the first edge after reset release.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Output registers hold stable while out_valid && !out_ready.
- Single-cycle ops:
  - Result loaded on the accepting edge; out_valid high next cycle (latency 1).
  - Full throughput when out_ready is held high.
- Move (00): alu_out=op2; addr_out=dst_addr; all opcodes.
- Arith (01):
  - 0 ADD, 1 SUB, 2 INC op1, 3 DEC op1, 5 NEG op1: all modulo 2^WIDTH, no carry out.
  - 4 MUL: see below.
  - Other opcodes: result 0.
- Logic (10):
  - 0 AND, 1 OR, 2 XOR, 3 NOT op1.
  - 4 SHL op1 by op2[$clog2(WIDTH)-1:0], 5 SHR logical by the same amount.
  - 6 CMP: result 0.
  - Other opcodes: result 0.
- addr_out = dst_addr for arith and logic results.
- Reserved (11): alu_out=0, addr_out=0, out_valid still asserted.
- Flags: updated from op1/op2 only when a logic-class op is loaded; held otherwise, including across move/arith/MUL/reserved. Comparison is unsigned.
- FSM states: IDLE, MUL.
  - IDLE --accept MUL--> MUL: load multiplicand=op1, multiplier=op2, acc=0, cnt=WIDTH; latch dst_addr.
  - In MUL, each edge performs one shift-add iteration and decrements cnt; busy=1; in_ready=0.
  - On the edge where cnt reaches 0: alu_out=low WIDTH bits of product, out_valid=1, state returns to IDLE.
  - Accept-to-out_valid latency is WIDTH+1 cycles.
- MUL entry requires output space: it is accepted only under the in_ready rule, so the completing edge never overwrites an unconsumed result.
- Simultaneous out handshake and new accept on the same edge: the new result replaces the old; no bubble.
- Reset mid-MUL: iteration aborted, no result produced, all outputs return to reset values.

Optional Feature:
- Macro ALU_SIGNED_CMP_EN.
- Defined: gt/lt use two's-complement signed comparison, and SHR with opcode 7 performs arithmetic right shift.
- Undefined: unsigned gt/lt; opcode 7 gives result 0.

Decomposition:
- Package alu_pkg holds:
  - op_type enum (OT_MOVE, OT_ARITH, OT_LOGIC, OT_RSVD).
  - Arith opcode constants (ADD, SUB, INC, DEC, MUL, NEG).
  - Logic opcode constants (AND, OR, XOR, NOT, SHL, SHR, CMP, SRA).
  - FSM state typedef.
- Sub-module alu_mul_seq: shift-add iterator with start/done, counter and accumulator. The top module owns the handshake, result mux and flags.

Test Plan:
- ADD op1=0x0003 op2=0x0004 dst=5, out_ready=1 -> next cycle alu_out=0x0007, addr_out=5, out_valid=1, flags unchanged.
- SUB op1=0x0000 op2=0x0001 -> alu_out=0xFFFF (wrap); DEC 0x0000 -> 0xFFFF.
- CMP op1=0xFFFF op2=0x0001 -> za=0, zb=0, eq=0, gt=1, lt=0 (unsigned). With ALU_SIGNED_CMP_EN -> gt=0, lt=1. A following ADD leaves flags held.
- MUL 0x0012*0x0034 dst=2 -> busy for 16 cycles, in_ready=0; out_valid 17 cycles after accept with alu_out=0x03A8, addr_out=2. Also 0xFFFF*0xFFFF -> 0x0001.
- Backpressure: out_ready=0 after an AND result -> out_valid, alu_out and in_ready=0 held for 5 cycles. Raising out_ready with in_valid high -> consume and accept on the same edge.
- rst_n low 3 cycles into MUL -> outputs 0 immediately (asynchronous); after release no stale product appears. op_type=11 -> alu_out=0, addr_out=0, out_valid=1.
